// File: rtl/id_exe_pipe_reg_pkg.sv
// Shared definitions for the decode-to-execute pipeline register and its
// hazard checker: datapath widths, the decoded-control bundle type and the
// bubble-tracking state encoding.
package id_exe_pipe_reg_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;
    localparam int CTRL_W    = 32;

    // Opaque decoded-control bundle; later stages slice it, this stage does not.
    typedef struct packed {
        logic [CTRL_W-1:0] bits;
    } ctrl_t;

    // Qualifier bits that a flush or an inserted bubble must clear.
    typedef struct packed {
        logic valid;
        logic rd_wr_en;
        logic mem_read;
    } exe_flags_t;

    // RUN: EXE holds a captured (or flushed) slot.
    // BUBBLE: the previous edge inserted a load-use bubble.
    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/pipe_flop.sv
// Generic flop bank with synchronous reset, synchronous clear and load
// enable. Priority: reset, then clear, then enable; otherwise holds.
module pipe_flop #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] r_q;

    // Register bank: clear beats load, hold when neither is asserted.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values; = here would create order-dependent races.
        if (rst_i || clr_i) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/id_exe_pipe_reg.sv
// Decode-to-execute pipeline register. Owns the decode stall and the
// load-use bubble decision: inserts one bubble on a load-use hazard, holds
// on execute backpressure, and kills the slot on a redirect flush.
// Optional build macro: LU_STALL_CNT_EN adds lu_stall_cnt_o, a wrapping
// count of inserted load-use bubbles.
module id_exe_pipe_reg #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ID_valid_i,
    input  logic [XLEN-1:0]   ID_pc_i,
    input  logic [CTRL_W-1:0] ID_ctrl_i,
    input  logic [4:0]        ID_rd_idx_i,
    input  logic              ID_rd_wr_en_i,
    input  logic              ID_mem_read_i,
    input  logic [XLEN-1:0]   ID_rs1_data_i,
    input  logic [XLEN-1:0]   ID_rs2_data_i,
    input  logic              ID_rs1_lu_hazard_i,
    input  logic              ID_rs2_lu_hazard_i,
    input  logic              EXE_stall_i,
    input  logic              flush_i,
    output logic              ID_stall_o,
    output logic              EXE_valid_o,
    output logic [XLEN-1:0]   EXE_pc_o,
    output logic [CTRL_W-1:0] EXE_ctrl_o,
    output logic [4:0]        EXE_rd_idx_o,
    output logic              EXE_rd_wr_en_o,
    output logic              EXE_mem_read_o,
    output logic [XLEN-1:0]   EXE_rs1_data_o,
    output logic [XLEN-1:0]   EXE_rs2_data_o,
    output logic              EXE_bubble_o
`ifdef LU_STALL_CNT_EN
    ,
    output logic [31:0]       lu_stall_cnt_o
`endif
);

    import id_exe_pipe_reg_pkg::*;

    localparam int DATA_W = 3 * XLEN + CTRL_W + REG_IDX_W;

    logic              w_lu;
    logic              w_do_bubble;
    logic              w_do_capture;
    logic              w_kill;
    logic              w_stall;
    exe_flags_t        w_flags_d;
    exe_flags_t        w_flags_q;
    logic [DATA_W-1:0] w_data_d;
    logic [DATA_W-1:0] w_data_q;
    pipe_state_e       r_state;

    // Per-cycle decision: flush beats stall, stall defers a hazard, a hazard
    // alone inserts a bubble, otherwise the decode bundle is captured.
    always_comb begin
        // NOTE: every signal here is assigned on every path, so no latch can be inferred.
        w_lu         = ID_valid_i & (ID_rs1_lu_hazard_i | ID_rs2_lu_hazard_i);
        w_do_bubble  = ~flush_i & ~EXE_stall_i & w_lu;
        w_do_capture = ~flush_i & ~EXE_stall_i & ~w_lu;
        w_kill       = flush_i | w_do_bubble;
        w_stall      = (w_lu | EXE_stall_i) & ~flush_i & ~rst_i;
    end

    assign ID_stall_o = w_stall;

    // Write-enable and mem-read only count when decode holds a real instruction.
    assign w_flags_d.valid    = ID_valid_i;
    assign w_flags_d.rd_wr_en = ID_valid_i & ID_rd_wr_en_i;
    assign w_flags_d.mem_read = ID_valid_i & ID_mem_read_i;

    assign w_data_d = {ID_pc_i, ID_ctrl_i, ID_rd_idx_i, ID_rs1_data_i, ID_rs2_data_i};

    // Qualifier flags: cleared by flush or bubble, loaded on capture.
    pipe_flop #(
        .W ($bits(exe_flags_t))
    ) u_flags (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_do_capture),
        .clr_i (w_kill),
        .d_i   (w_flags_d),
        .q_o   (w_flags_q)
    );

    // Payload: only ever loaded on capture; flush and bubble leave it alone.
    // NOTE: the payload bank is reset even though it is plain data, because every EXE output must read 0 after reset.
    pipe_flop #(
        .W (DATA_W)
    ) u_data (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_do_capture),
        .clr_i (1'b0),
        .d_i   (w_data_d),
        .q_o   (w_data_q)
    );

    // Bubble tracker: enter BUBBLE on an inserted bubble, hold on stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RUN;
        end else if (flush_i) begin
            r_state <= RUN;
        end else if (EXE_stall_i) begin
            r_state <= r_state;
        end else if (w_lu) begin
            r_state <= BUBBLE;
        end else begin
            r_state <= RUN;
        end
    end

    assign EXE_valid_o    = w_flags_q.valid;
    assign EXE_rd_wr_en_o = w_flags_q.rd_wr_en;
    assign EXE_mem_read_o = w_flags_q.mem_read;
    assign EXE_bubble_o   = (r_state == BUBBLE);

    assign {EXE_pc_o, EXE_ctrl_o, EXE_rd_idx_o, EXE_rs1_data_o, EXE_rs2_data_o} = w_data_q;

`ifdef LU_STALL_CNT_EN
    logic [31:0] r_lu_stall_cnt;

    // Bubble counter: survives flush, wraps naturally at 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lu_stall_cnt <= '0;
        end else if (w_do_bubble) begin
            r_lu_stall_cnt <= r_lu_stall_cnt + 32'd1;
        end
    end

    assign lu_stall_cnt_o = r_lu_stall_cnt;
`endif

`ifndef SYNTHESIS
    logic r_bubble_ins;

    // Remembers that the previous edge inserted a bubble (cleared by any stall or flush edge).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bubble_ins <= 1'b0;
        end else begin
            r_bubble_ins <= w_do_bubble;
        end
    end

    // Right after a bubble the load sits in MEM and is forwarded, so the
    // bypass units must not still report a load-use hazard.
    a_no_lu_after_bubble : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (r_bubble_ins && r_state == BUBBLE && !flush_i && !EXE_stall_i) |-> !w_lu
    );
`endif

endmodule

// File: doc/id_exe_pipe_reg.md
Name: id_exe_pipe_reg

Overview:
- Decode-to-execute pipeline register. It consumes the forwarded operands and load-use hazard flags produced by the per-source-register bypass units in decode.
- It inserts a one-cycle bubble on a load-use hazard, holds on execute backpressure, kills on redirect flush, and presents a registered instruction bundle to EXE.
- It is the sole owner of the decode stall and bubble decision.

Parameters:
- XLEN, 64, datapath width of PC and operands.
- CTRL_W, 32, width of opaque decoded-control bundle passed through unchanged.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- ID_valid_i  in  1  decode holds a valid instruction.
- ID_pc_i  in  XLEN  decode PC.
- ID_ctrl_i  in  CTRL_W  decoded control bundle.
- ID_rd_idx_i  in  5  destination register.
- ID_rd_wr_en_i  in  1  instruction writes rd.
- ID_mem_read_i  in  1  instruction is a load.
- ID_rs1_data_i, ID_rs2_data_i  in  XLEN each  bypassed operands.
- ID_rs1_lu_hazard_i, ID_rs2_lu_hazard_i  in  1 each  load-use flags from the bypass units.
- EXE_stall_i  in  1  execute cannot accept (multi-cycle op).
- flush_i  in  1  redirect; kill the younger instruction.
- ID_stall_o  out  1  decode must hold its instruction this cycle (combinational).
- EXE_valid_o, EXE_pc_o, EXE_ctrl_o, EXE_rd_idx_o, EXE_rd_wr_en_o, EXE_mem_read_o, EXE_rs1_data_o, EXE_rs2_data_o  out  registered bundle.
- EXE_bubble_o  out  1  current EXE slot is an inserted load-use bubble.

Behaviour:
- Synchronous, active-high reset (this is fixed): one clock; reset is synchronous and active-high.
  - Reset values: all EXE_* outputs 0, EXE_bubble_o 0, state RUN.
- Combinational signals:
  - lu = ID_valid_i & (ID_rs1_lu_hazard_i | ID_rs2_lu_hazard_i).
  - ID_stall_o = (lu | EXE_stall_i) & ~flush_i.
  - ID_stall_o is 0 during reset.
- Per-edge priority, highest first:
  1. rst_i: reset values.
  2. flush_i: EXE_valid_o, EXE_rd_wr_en_o, EXE_mem_read_o and EXE_bubble_o go to 0. Flush wins even when EXE_stall_i=1. Other fields hold. State goes to RUN.
  3. EXE_stall_i: every output register holds, including EXE_bubble_o. State holds. A hazard present during the stall is deferred, not bubbled.
  4. lu: EXE_valid_o, EXE_rd_wr_en_o and EXE_mem_read_o go to 0; EXE_bubble_o goes to 1. Data and PC fields hold. State goes to BUBBLE.
  5. Otherwise capture the ID bundle: EXE_valid_o<=ID_valid_i and all fields load. The write-enable and mem-read fields are qualified with ID_valid_i. EXE_bubble_o goes to 0. State goes to RUN.
- Latency is one cycle from ID acceptance to the EXE_* outputs.
- FSM states: RUN and BUBBLE.
  - BUBBLE means the previous edge inserted a bubble. The load has since moved to MEM, so the bypass units forward from MEM and the hazard flags must be 0.
  - If lu=1 while in BUBBLE (no intervening stall or flush), this is a protocol violation. The RTL still inserts another bubble (safe). Simulation-only assertion code flags it.
- No combinational path from any ID_* data input to any EXE_* output.
- A flush and a hazard in the same cycle produce a flush only, with no bubble flag and ID_stall_o=0. The fetch redirect squashes decode.

Optional Feature:
- Macro LU_STALL_CNT_EN.
  - Defined: adds output lu_stall_cnt_o [31:0]. It resets to 0 and increments on every edge where rule 4 fires (bubble inserted). It wraps at 2^32-1 to 0 and is not cleared by flush.
  - Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - XLEN and REG_IDX_W=5 constants.
  - The CTRL_W constant and decoded-control struct typedef.
  - The FSM state enum {RUN, BUBBLE}, used by this block and the hazard-assertion checker.
- No sub-module. Optional: a generic enable/clear flop-bank helper, pipe_flop, reused by later stage registers.

Test Plan:
- Normal flow: ID_valid=1, pc=0x1000, rs1=0xAA, rs2=0x55, no hazards/stall -> next edge EXE_valid=1, EXE_pc=0x1000, data matched; ID_stall_o=0.
- Load-use: rs1 hazard=1 for one cycle, pc=0x2004 -> ID_stall_o=1 that cycle; next edge EXE_valid=0, EXE_bubble=1, EXE_rd_wr_en=0. Following cycle with hazard=0 and rs1=0x1234 (MEM-forwarded) -> EXE_valid=1, EXE_pc=0x2004, EXE_rs1_data=0x1234, EXE_bubble=0.
- EXE stall: EXE_stall_i=1 for 3 cycles with a hazard also asserted -> outputs frozen for 3 edges, ID_stall_o=1 throughout, no bubble. After release with hazard still 1 -> exactly one bubble.
- Flush vs stall/hazard: flush_i=1 with EXE_stall_i=1 and lu=1 -> next edge EXE_valid=0, EXE_bubble=0, ID_stall_o=0 in that cycle.
- Reset mid-bubble: assert rst_i in the cycle after bubble insertion -> all outputs 0, state RUN; the first post-reset instruction passes with 1-cycle latency.
- LU_STALL_CNT_EN: 5 separate load-use events plus 2 flushes -> lu_stall_cnt_o=5. Preload the counter to 0xFFFFFFFF via force, trigger one bubble -> counter reads 0.
